clock_time_counter: RTL and testbench

- Digital-clock timekeeping core: integrated prescaler plus 24-hour hh:mm:ss counter.
- Integer prescaler divides the system clock into a one-cycle 1 Hz tick enable. No derived clock is used.
- In run mode the tick advances seconds with ripple carry into minutes and hours.
- In set mode counting is paused and the selected field is stepped up or down from pushbutton inputs.
- Feeds the display/BCD stage with three 6-bit binary counts.

---
 rtl/clock_time_counter.sv | 104 ++++++++++
 tb/tb_clock_time_counter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/clock_time_counter.sv
// 24-hour hh:mm:ss timekeeping core with an integrated 1 Hz prescaler.
// Set mode pauses counting and steps one selected field from edge-detected buttons.
module clock_time_counter #(
    parameter int unsigned DIV = 100000000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_mode,
    input  logic       i_set,
    input  logic       i_sec,
    input  logic       i_min,
    input  logic       i_hour,
    input  logic       i_up,
    input  logic       i_down,
    output logic [5:0] o_count_h,
    output logic [5:0] o_count_m,
    output logic [5:0] o_count_s
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CntMax = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          up_q, down_q, mode_q;
    logic [5:0]    h_q, h_d, m_q, m_d, s_q, s_d;
    logic          tick, up_evt, down_evt;

    // Single-step a field with wrap in both directions; no carry leaves the field.
    function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] max,
                                             input logic up);
        if (up) begin
            return (v == max) ? 6'd0 : v + 6'd1;
        end
        return (v == 6'd0) ? max : v - 6'd1;
    endfunction

    // The count is held at zero in set mode, so a partial second is always discarded.
    always_comb begin
        tick  = ~i_mode & ~mode_q & (cnt_q == CntMax);
        cnt_d = cnt_q;
        if (i_mode || cnt_q == CntMax) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign up_evt   = i_up & ~up_q;
    assign down_evt = i_down & ~down_q;

    always_comb begin
        h_d = h_q;
        m_d = m_q;
        s_d = s_q;
        if (!i_mode) begin
            if (tick) begin
                if (s_q == 6'd59) begin
                    s_d = 6'd0;
                    if (m_q == 6'd59) begin
                        m_d = 6'd0;
                        h_d = (h_q == 6'd23) ? 6'd0 : h_q + 6'd1;
                    end else begin
                        m_d = m_q + 6'd1;
                    end
                end else begin
                    s_d = s_q + 6'd1;
                end
            end
        end else if (i_set && (up_evt ^ down_evt)) begin
            if (i_sec) begin
                s_d = step_wrap(s_q, 6'd59, up_evt);
            end else if (i_min) begin
                m_d = step_wrap(m_q, 6'd59, up_evt);
            end else if (i_hour) begin
                h_d = step_wrap(h_q, 6'd23, up_evt);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q  <= '0;
            up_q   <= 1'b0;
            down_q <= 1'b0;
            mode_q <= 1'b0;
            h_q    <= 6'd0;
            m_q    <= 6'd0;
            s_q    <= 6'd0;
        end else begin
            cnt_q  <= cnt_d;
            up_q   <= i_up;
            down_q <= i_down;
            mode_q <= i_mode;
            h_q    <= h_d;
            m_q    <= m_d;
            s_q    <= s_d;
        end
    end

    assign o_count_h = h_q;
    assign o_count_m = m_q;
    assign o_count_s = s_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed self-checking bench for clock_time_counter with DIV=4.
module tb_clock_time_counter;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_mode = 1'b0;
    logic       i_set = 1'b0;
    logic       i_sec = 1'b0;
    logic       i_min = 1'b0;
    logic       i_hour = 1'b0;
    logic       i_up = 1'b0;
    logic       i_down = 1'b0;
    logic [5:0] o_count_h, o_count_m, o_count_s;

    int tests = 0;
    int fails = 0;

    clock_time_counter #(.DIV(4)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_mode    (i_mode),
        .i_set     (i_set),
        .i_sec     (i_sec),
        .i_min     (i_min),
        .i_hour    (i_hour),
        .i_up      (i_up),
        .i_down    (i_down),
        .o_count_h (o_count_h),
        .o_count_m (o_count_m),
        .o_count_s (o_count_s)
    );

    always #5 i_clk = ~i_clk;

    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_hms(input string tag, input int h, input int m, input int s);
        check({tag, ".h"}, o_count_h, 6'(h));
        check({tag, ".m"}, o_count_m, 6'(m));
        check({tag, ".s"}, o_count_s, 6'(s));
    endtask

    task automatic pulse_up();
        i_up = 1'b1;
        step(1);
        i_up = 1'b0;
        step(1);
    endtask

    task automatic pulse_down();
        i_down = 1'b1;
        step(1);
        i_down = 1'b0;
        step(1);
    endtask

    initial begin
        // Reset state
        #2;
        check_hms("reset", 0, 0, 0);
        step(1);
        i_reset = 1'b1;

        // Run mode: first tick on the 4th clock, then every 4 clocks
        step(3);
        check("run_pre_tick.s", o_count_s, 6'd0);
        step(1);
        check("run_tick1.s", o_count_s, 6'd1);
        step(3);
        check("run_pre_tick2.s", o_count_s, 6'd1);
        step(1);
        check("run_tick2.s", o_count_s, 6'd2);

        // Set mode pauses counting
        i_mode = 1'b1;
        i_set  = 1'b1;
        step(10);
        check_hms("paused", 0, 0, 2);

        // Load 23:59:58 with down steps (exercise wrap 0->23 and 0->59)
        i_hour = 1'b1;
        pulse_down();
        check_hms("hour_down_wrap", 23, 0, 2);
        i_hour = 1'b0;
        i_min  = 1'b1;
        pulse_down();
        check_hms("min_down_wrap", 23, 59, 2);
        i_min = 1'b0;
        i_sec = 1'b1;
        repeat (4) pulse_down();
        check_hms("loaded", 23, 59, 58);
        i_sec  = 1'b0;
        i_set  = 1'b0;

        // Leave set mode: first tick DIV clocks later, then rollover
        i_mode = 1'b0;
        step(3);
        check("resume_pre.s", o_count_s, 6'd58);
        step(1);
        check_hms("tick_59", 23, 59, 59);
        step(4);
        check_hms("rollover", 0, 0, 0);

        // Held up button gives one event only
        i_mode = 1'b1;
        i_set  = 1'b1;
        i_sec  = 1'b1;
        i_up   = 1'b1;
        step(5);
        check("held_up.s", o_count_s, 6'd1);
        i_up = 1'b0;
        step(1);
        pulse_up();
        pulse_up();
        check("toggled_up.s", o_count_s, 6'd3);

        // Minutes down at 0 -> 59, hours unchanged; hours up at 23 -> 0
        i_sec = 1'b0;
        i_min = 1'b1;
        pulse_down();
        check_hms("min_down", 0, 59, 3);
        i_min  = 1'b0;
        i_hour = 1'b1;
        pulse_down();
        check("hour_to_23.h", o_count_h, 6'd23);
        pulse_up();
        check_hms("hour_up_wrap", 0, 59, 3);
        i_hour = 1'b0;

        // Select priority: sec over min
        i_sec = 1'b1;
        i_min = 1'b1;
        pulse_up();
        check_hms("priority", 0, 59, 4);
        i_min = 1'b0;

        // Up and down together: no change
        i_up   = 1'b1;
        i_down = 1'b1;
        step(1);
        i_up   = 1'b0;
        i_down = 1'b0;
        step(1);
        check_hms("up_and_down", 0, 59, 4);

        // i_set low ignores buttons
        i_set = 1'b0;
        pulse_up();
        check_hms("set_low", 0, 59, 4);

        // Load 12:34:56
        i_set  = 1'b1;
        i_sec  = 1'b0;
        i_hour = 1'b1;
        repeat (12) pulse_up();
        i_hour = 1'b0;
        i_min  = 1'b1;
        repeat (35) pulse_up();
        i_min = 1'b0;
        i_sec = 1'b1;
        repeat (52) pulse_up();
        i_sec = 1'b0;
        i_set = 1'b0;
        check_hms("loaded2", 12, 34, 56);

        // Asynchronous reset mid-run
        i_mode = 1'b0;
        step(2);
        check_hms("run_mid", 12, 34, 56);
        #2;
        i_reset = 1'b0;
        #1;
        check_hms("async_reset", 0, 0, 0);
        step(1);
        #1;
        i_reset = 1'b1;
        step(3);
        check("post_reset_pre.s", o_count_s, 6'd0);
        step(1);
        check_hms("post_reset_tick", 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
